// File: rtl/mem_pkg.sv
// Shared types and elaboration helpers for the word-wide memory controller.
// Lane 0 is the lowest byte address and sits in the most-significant byte of a word.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  // Bit position of the least-significant bit of byte lane `lane` in a word of `bpw` lanes.
  function automatic int lane_lsb(input int lane, input int bpw);
    return 8 * (bpw - 1 - lane);
  endfunction

  function automatic bit params_ok(input int bpw, input int depth, input int addr_w,
                                   input int wait_states);
    bit ok;
    ok = (bpw == 1 || bpw == 2 || bpw == 4 || bpw == 8);
    ok = ok && (depth > 0) && ((depth % bpw) == 0);
    ok = ok && (addr_w > 0) && (addr_w <= 31) && (depth <= (1 << addr_w));
    ok = ok && (wait_states >= 0);
    return ok;
  endfunction

endpackage

// File: rtl/mem_ctrl_array.sv
// Byte-organised storage with per-lane write enables and a combinational word read.
// Contents are deliberately not reset.
module mem_byte_array
  import mem_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int BYTES_PER_WORD = 2,
  parameter int DEPTH_BYTES    = 1024
) (
  input  logic                        clk,
  input  logic [BYTES_PER_WORD-1:0]   we_i,
  input  logic [ADDR_W-1:0]           addr_i,
  input  logic [8*BYTES_PER_WORD-1:0] wdata_i,
  output logic [8*BYTES_PER_WORD-1:0] rdata_o
);

  localparam int IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

  logic [7:0]       memory_array [0:DEPTH_BYTES-1];
  logic [IDX_W-1:0] lane_idx     [BYTES_PER_WORD];
  logic             lane_ok      [BYTES_PER_WORD];

  // Lanes past the end of storage are masked here so the index never leaves the array.
  always_comb begin
    for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
      lane_ok[i]  = ({1'b0, addr_i} + (ADDR_W+1)'(i)) < (ADDR_W+1)'(DEPTH_BYTES);
      lane_idx[i] = IDX_W'({1'b0, addr_i} + (ADDR_W+1)'(i));
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
      if (lane_ok[i]) begin
        rdata_o[lane_lsb(i, BYTES_PER_WORD) +: 8] = memory_array[lane_idx[i]];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
      if (we_i[BYTES_PER_WORD-1-i] && lane_ok[i]) begin
        memory_array[lane_idx[i]] <= wdata_i[lane_lsb(i, BYTES_PER_WORD) +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Word-wide memory block with valid/ready request/response handshake, programmable
// wait states, big-endian byte enables and misalignment/range error reporting.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int BYTES_PER_WORD = 2,
  parameter int DEPTH_BYTES    = 1024,
  parameter int WAIT_STATES    = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [8*BYTES_PER_WORD-1:0] req_wdata,
  input  logic [BYTES_PER_WORD-1:0]   req_be,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [8*BYTES_PER_WORD-1:0] rsp_rdata,
  output logic                        rsp_err
);

  localparam int DATA_W = 8 * BYTES_PER_WORD;
  localparam int CNT_W  = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam int OFF_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  if (!params_ok(BYTES_PER_WORD, DEPTH_BYTES, ADDR_W, WAIT_STATES)) begin : g_param_check
    $error("mem_ctrl: illegal parameter combination");
  end

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BYTES_PER_WORD-1:0] be_q, be_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic                access;
  logic                misaligned;
  logic                out_of_range;
  logic                acc_err;
  logic [BYTES_PER_WORD-1:0] arr_we;
  logic [DATA_W-1:0]   arr_rdata;

  assign misaligned   = (BYTES_PER_WORD > 1) && (addr_q[OFF_W-1:0] != '0);
  assign out_of_range = ({1'b0, addr_q} + (ADDR_W+1)'(BYTES_PER_WORD))
                        > (ADDR_W+1)'(DEPTH_BYTES);
  assign acc_err      = misaligned || out_of_range;
  assign arr_we       = (access && write_q && !acc_err) ? be_q : '0;

  mem_byte_array #(
    .ADDR_W         (ADDR_W),
    .BYTES_PER_WORD (BYTES_PER_WORD),
    .DEPTH_BYTES    (DEPTH_BYTES)
  ) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (arr_rdata)
  );

  // The access happens in the first RESP cycle (rsp_valid still low), which gives a
  // request accepted at edge N a response after edge N+1+WAIT_STATES.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    access      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (!rsp_valid_q) begin
          access      = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = acc_err;
          rsp_rdata_d = (acc_err || write_q) ? '0 : arr_rdata;
        end else if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: default build with a scoreboard, plus a
// zero-wait-state build and a 4-lane / 3-wait-state build.
module tb_mem_ctrl;

  logic        clk;
  logic        rst_n;

  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr, req_wdata;
  logic [1:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_rdata;

  logic        z_req_valid, z_req_ready, z_req_write;
  logic [15:0] z_req_addr, z_req_wdata;
  logic [1:0]  z_req_be;
  logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [15:0] z_rsp_rdata;

  logic        w_req_valid, w_req_ready, w_req_write;
  logic [15:0] w_req_addr;
  logic [31:0] w_req_wdata;
  logic [3:0]  w_req_be;
  logic        w_rsp_valid, w_rsp_ready, w_rsp_err;
  logic [31:0] w_rsp_rdata;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] model [0:1023];
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         acc, lat;

  mem_ctrl dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  mem_ctrl #(.WAIT_STATES(0)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  mem_ctrl #(.BYTES_PER_WORD(4), .WAIT_STATES(3)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_write(w_req_write),
    .req_addr(w_req_addr), .req_wdata(w_req_wdata), .req_be(w_req_be),
    .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready),
    .rsp_rdata(w_rsp_rdata), .rsp_err(w_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: compare every completed response handshake on the default build.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rsp: got rdata=%h err=%b, required no response", rsp_rdata, rsp_err);
      end else begin
        e = sb_q.pop_front();
        if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
          n_fail++;
          $display("FAIL rsp_addr_%h: got rdata=%h err=%b, required rdata=%h err=%b",
                   e.addr, rsp_rdata, rsp_err, e.rdata, e.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request on the default build; returns edges waited for accept and
  // edges from accept until rsp_valid is seen.
  task automatic send(input logic w, input logic [15:0] a, input logic [15:0] d,
                      input logic [1:0] be, output int acc_wait, output int latency);
    exp_t e;
    logic err;
    err     = a[0] || (int'(a) + 2 > 1024);
    e.addr  = a;
    e.err   = err;
    e.rdata = 16'h0000;
    if (!w && !err) e.rdata = {model[int'(a)], model[int'(a) + 1]};
    if (w && !err) begin
      if (be[1]) model[int'(a)]     = d[15:8];
      if (be[0]) model[int'(a) + 1] = d[7:0];
    end
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    acc_wait = 0;
    while (!req_ready && acc_wait < 20) begin
      tick();
      acc_wait++;
    end
    latency = -1;
    if (!req_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: got req_ready=0 for 20 cycles, required 1");
      req_valid = 1'b0;
    end else begin
      sb_q.push_back(e);
      tick();
      req_valid = 1'b0;
      latency = 0;
      while (!rsp_valid && latency < 20) begin
        tick();
        latency++;
      end
      if (!rsp_valid) begin
        n_cmp++; n_fail++;
        $display("FAIL rsp_timeout: got rsp_valid=0 for 20 cycles, required 1");
      end
    end
  endtask

  task automatic z_xact(input logic w, input logic [15:0] a, input logic [15:0] d,
                        output int latency);
    int waitc = 0;
    z_req_valid = 1'b1; z_req_write = w; z_req_addr = a; z_req_wdata = d; z_req_be = 2'b11;
    while (!z_req_ready && waitc < 20) begin tick(); waitc++; end
    tick();
    z_req_valid = 1'b0;
    latency = 0;
    while (!z_rsp_valid && latency < 20) begin tick(); latency++; end
  endtask

  task automatic w_xact(input logic w, input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] be, output int latency);
    int waitc = 0;
    w_req_valid = 1'b1; w_req_write = w; w_req_addr = a; w_req_wdata = d; w_req_be = be;
    while (!w_req_ready && waitc < 20) begin tick(); waitc++; end
    tick();
    w_req_valid = 1'b0;
    latency = 0;
    while (!w_rsp_valid && latency < 20) begin tick(); latency++; end
  endtask

  task automatic test_reset();
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b, required 1", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h, required 0000", rsp_rdata); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b, required 0", rsp_err); end
  endtask

  task automatic test_write_read();
    send(1'b1, 16'h0002, 16'hABCD, 2'b11, acc, lat);
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL wr_latency: got %0d, required 2", lat); end
    n_cmp++; if (dut0.u_array.memory_array[2] !== 8'hAB) begin n_fail++; $display("FAIL wr_byte2: got %h, required ab", dut0.u_array.memory_array[2]); end
    n_cmp++; if (dut0.u_array.memory_array[3] !== 8'hCD) begin n_fail++; $display("FAIL wr_byte3: got %h, required cd", dut0.u_array.memory_array[3]); end
    send(1'b0, 16'h0002, 16'h0000, 2'b00, acc, lat);
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL rd_latency: got %0d, required 2", lat); end
    n_cmp++; if (rsp_rdata !== 16'hABCD) begin n_fail++; $display("FAIL rd_data: got %h, required abcd", rsp_rdata); end
  endtask

  task automatic test_byte_enable();
    model[4] = 8'h11; model[5] = 8'h22;
    dut0.u_array.memory_array[4] = 8'h11;
    dut0.u_array.memory_array[5] = 8'h22;
    send(1'b1, 16'h0004, 16'hFFEE, 2'b01, acc, lat);
    n_cmp++; if (dut0.u_array.memory_array[4] !== 8'h11) begin n_fail++; $display("FAIL be_lane_off: got %h, required 11", dut0.u_array.memory_array[4]); end
    n_cmp++; if (dut0.u_array.memory_array[5] !== 8'hEE) begin n_fail++; $display("FAIL be_lane_on: got %h, required ee", dut0.u_array.memory_array[5]); end
    send(1'b0, 16'h0004, 16'h0000, 2'b11, acc, lat);
    n_cmp++; if (rsp_rdata !== 16'h11EE) begin n_fail++; $display("FAIL be_readback: got %h, required 11ee", rsp_rdata); end
  endtask

  task automatic test_errors();
    send(1'b0, 16'h0003, 16'h0000, 2'b11, acc, lat);
    n_cmp++; if (rsp_err !== 1'b1 || rsp_rdata !== 16'h0) begin n_fail++; $display("FAIL misaligned_rd: got err=%b rdata=%h, required err=1 rdata=0000", rsp_err, rsp_rdata); end
    send(1'b1, 16'h0400, 16'h1234, 2'b11, acc, lat);
    n_cmp++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL range_wr_err: got %b, required 1", rsp_err); end
    n_cmp++; if (dut0.u_array.memory_array[0] !== model[0] || dut0.u_array.memory_array[1] !== model[1]) begin
      n_fail++; $display("FAIL range_wr_nowrite: got %h%h, required %h%h", dut0.u_array.memory_array[0], dut0.u_array.memory_array[1], model[0], model[1]);
    end
    send(1'b1, 16'h0005, 16'hBEEF, 2'b11, acc, lat);
    n_cmp++; if (dut0.u_array.memory_array[5] !== 8'hEE || dut0.u_array.memory_array[6] !== model[6]) begin
      n_fail++; $display("FAIL misaligned_wr_nowrite: got %h%h, required ee%h", dut0.u_array.memory_array[5], dut0.u_array.memory_array[6], model[6]);
    end
    send(1'b1, 16'h03FE, 16'h5AA5, 2'b11, acc, lat);
    send(1'b0, 16'h03FE, 16'h0000, 2'b11, acc, lat);
    n_cmp++; if (rsp_err !== 1'b0 || rsp_rdata !== 16'h5AA5) begin n_fail++; $display("FAIL last_word: got err=%b rdata=%h, required err=0 rdata=5aa5", rsp_err, rsp_rdata); end
  endtask

  task automatic test_hold();
    tick();
    rsp_ready = 1'b0;
    send(1'b0, 16'h0002, 16'h0000, 2'b11, acc, lat);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0002; req_wdata = 16'h0000; req_be = 2'b11;
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid_%0d: got %b, required 1", k, rsp_valid); end
      n_cmp++; if (rsp_rdata !== 16'hABCD) begin n_fail++; $display("FAIL hold_rdata_%0d: got %h, required abcd", k, rsp_rdata); end
      n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL hold_req_ready_%0d: got %b, required 0", k, req_ready); end
      tick();
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    tick();
    n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release: got req_ready=%b rsp_valid=%b, required 1 0", req_ready, rsp_valid); end
    send(1'b0, 16'h0002, 16'h0000, 2'b11, acc, lat);
    n_cmp++; if (acc !== 0) begin n_fail++; $display("FAIL next_accept: got %0d waits, required 0", acc); end
    n_cmp++; if (rsp_rdata !== 16'hABCD) begin n_fail++; $display("FAIL ignored_req: got %h, required abcd", rsp_rdata); end
  endtask

  task automatic test_back_to_back();
    int bad_lat = 0;
    for (int t = 0; t < 16; t++) begin
      send(1'($urandom_range(0, 1)), 16'h0100 + 16'(2 * $urandom_range(0, 5)),
           16'($urandom), 2'($urandom_range(0, 3)), acc, lat);
      if (lat != 2) bad_lat++;
    end
    n_cmp++; if (bad_lat !== 0) begin n_fail++; $display("FAIL b2b_latency: got %0d off-latency responses, required 0", bad_lat); end
  endtask

  task automatic test_reset_mid_wait();
    int seen = 0;
    tick();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0006; req_wdata = 16'h5555; req_be = 2'b11;
    @(posedge clk); #2;
    req_valid = 1'b0;
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_pre_wait: got req_ready=%b, required 0", req_ready); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 16'h0 || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL rst_async: got ready=%b valid=%b rdata=%h err=%b, required 1 0 0000 0", req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++; if (dut0.u_array.memory_array[6] !== model[6] || dut0.u_array.memory_array[7] !== model[7]) begin
      n_fail++; $display("FAIL rst_dropped_write: got %h%h, required %h%h", dut0.u_array.memory_array[6], dut0.u_array.memory_array[7], model[6], model[7]);
    end
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b, required 1", req_ready); end
    for (int k = 0; k < 4; k++) begin
      if (rsp_valid) seen++;
      tick();
    end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL rst_no_rsp: got %0d valid cycles, required 0", seen); end
  endtask

  task automatic test_wait0();
    z_xact(1'b1, 16'h0010, 16'h1357, lat);
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL w0_wr_latency: got %0d, required 1", lat); end
    z_xact(1'b0, 16'h0010, 16'h0000, lat);
    n_cmp++; if (lat !== 1 || z_rsp_rdata !== 16'h1357) begin n_fail++; $display("FAIL w0_read: got lat=%0d rdata=%h, required 1 1357", lat, z_rsp_rdata); end
    z_xact(1'b0, 16'h03FF, 16'h0000, lat);
    n_cmp++; if (z_rsp_err !== 1'b1 || z_rsp_rdata !== 16'h0) begin n_fail++; $display("FAIL w0_err: got err=%b rdata=%h, required 1 0000", z_rsp_err, z_rsp_rdata); end
  endtask

  task automatic test_bpw4_wait3();
    logic [31:0] got;
    w_xact(1'b1, 16'h0008, 32'h01020304, 4'hF, lat);
    n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL w3_wr_latency: got %0d, required 4", lat); end
    got = {dut1.u_array.memory_array[8], dut1.u_array.memory_array[9],
           dut1.u_array.memory_array[10], dut1.u_array.memory_array[11]};
    n_cmp++; if (got !== 32'h01020304) begin n_fail++; $display("FAIL w3_bytes: got %h, required 01020304", got); end
    w_xact(1'b1, 16'h0008, 32'hAABBCCDD, 4'b0100, lat);
    w_xact(1'b0, 16'h0008, 32'h0, 4'h0, lat);
    n_cmp++; if (lat !== 4 || w_rsp_rdata !== 32'h01BB0304) begin n_fail++; $display("FAIL w3_read: got lat=%0d rdata=%h, required 4 01bb0304", lat, w_rsp_rdata); end
    w_xact(1'b0, 16'h000A, 32'h0, 4'hF, lat);
    n_cmp++; if (w_rsp_err !== 1'b1 || w_rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL w3_misaligned: got err=%b rdata=%h, required 1 00000000", w_rsp_err, w_rsp_rdata); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b1;
    z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_be = '0; z_rsp_ready = 1'b1;
    w_req_valid = 1'b0; w_req_write = 1'b0; w_req_addr = '0; w_req_wdata = '0; w_req_be = '0; w_rsp_ready = 1'b1;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      model[i] = 8'($urandom);
      dut0.u_array.memory_array[i] = model[i];
    end
    model[6] = 8'h12; model[7] = 8'h34;
    dut0.u_array.memory_array[6] = 8'h12;
    dut0.u_array.memory_array[7] = 8'h34;
    #2;
    test_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    test_write_read();
    test_byte_enable();
    test_errors();
    test_hold();
    test_back_to_back();
    test_reset_mid_wait();
    test_wait0();
    test_bpw4_wait3();
    repeat (3) tick();
    n_cmp++; if (sb_q.size() !== 0) begin n_fail++; $display("FAIL sb_drain: got %0d pending, required 0", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Parametrised successor to the single-cycle byte memory. It is a word-wide memory block with a valid/ready request/response handshake, programmable wait states, per-byte write enables, and error reporting for misaligned and out-of-range accesses. It sits between the CPU load/store unit and the system memory array inside `system`. Byte order is big-endian: the lowest address maps to the most-significant lane.

Parameters:
- ADDR_W, 16, request byte-address width.
- BYTES_PER_WORD, 2, data lanes per access; must be 1, 2, 4 or 8.
- DEPTH_BYTES, 1024, storage size in bytes; must be ≤ 2^ADDR_W and a multiple of BYTES_PER_WORD.
- WAIT_STATES, 1, extra cycles between request accept and response; 0 is legal.

Ports:
- clk, in, 1, system clock; all state changes on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- req_valid, in, 1, request present.
- req_ready, out, 1, block can accept a request.
- req_write, in, 1, 1 = write, 0 = read.
- req_addr, in, ADDR_W, byte address of the word.
- req_wdata, in, 8*BYTES_PER_WORD, write data; bits [8*BPW-1 -: 8] go to req_addr.
- req_be, in, BYTES_PER_WORD, byte enables; MSB corresponds to lane req_addr.
- rsp_valid, out, 1, response present.
- rsp_ready, in, 1, consumer accepts the response.
- rsp_rdata, out, 8*BYTES_PER_WORD, read data; 0 for writes and for errors.
- rsp_err, out, 1, access was misaligned or out of range.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. Storage contents are not cleared by reset.
- Preload: storage is a byte array named memory_array[0:DEPTH_BYTES-1], reachable hierarchically for bench preload.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch write, addr, wdata and be.
  - Go to WAIT if WAIT_STATES>0, otherwise go directly to RESP.
- WAIT:
  - req_ready=0.
  - Counter loads WAIT_STATES-1 on accept and decrements each cycle.
  - At 0, perform the access and go to RESP.
- Access rules:
  - Error condition: addr % BYTES_PER_WORD ≠ 0, or addr+BYTES_PER_WORD > DEPTH_BYTES.
  - On error: rsp_err=1, no byte is written, rdata=0.
  - Write: for each lane i with be[BPW-1-i]=1, memory_array[addr+i] = wdata byte i, counted from the MSB. Disabled lanes are untouched.
  - Read: rdata = {memory_array[addr], …, memory_array[addr+BPW-1]}. be is ignored on reads.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready=1.
  - When rsp_ready=1, go to IDLE in the same edge and drop rsp_valid.
  - No new request is accepted in RESP (req_ready=0). A request is therefore accepted no earlier than the cycle after the response handshake.
- Latency: a request accepted at edge N raises rsp_valid after edge N+1+WAIT_STATES. With WAIT_STATES=0, rsp_valid is high after edge N+1.
- Ordering: strictly one outstanding request. Read-after-write to the same address returns the new data.
- Reset mid-operation (any state):
  - Return to IDLE immediately and apply all reset values.
  - A write whose access had not yet been performed is dropped.
  - A write already performed is kept.
- Stability: changes on req_* inputs while not in IDLE have no effect.

Decomposition:
- Package mem_pkg:
  - state enum {IDLE, WAIT, RESP}.
  - localparam function for the lane-index mapping.
  - Parameter legality checks via an elaboration-time assertion.
- Sub-module mem_byte_array (storage only):
  - Ports: clk, byte-wide write enables, addr, wdata, rdata.
  - Holds memory_array with no reset.
- mem_ctrl contains the FSM, wait counter, error check and response registers.

Test Plan (defaults: BPW=2, WAIT_STATES=1, DEPTH=1024):
- Write addr=0x0002, wdata=0xABCD, be=2'b11, then read 0x0002 → memory_array[2]=0xAB, memory_array[3]=0xCD, rsp_rdata=0xABCD, rsp_err=0; rsp_valid rises 2 edges after each accept.
- Preload [4]=0x11, [5]=0x22, then write addr=4, wdata=0xFFEE, be=2'b01 → read returns 0x11EE.
- Read addr=0x0003 (misaligned) and write addr=0x0400 (out of range) → rsp_err=1, rsp_rdata=0, array unchanged.
- Hold rsp_ready=0 for 5 cycles on a read returning 0xABCD → rsp_valid and rsp_rdata stay at 0xABCD and req_ready stays 0; release → back to IDLE, next request accepted on the following cycle.
- Rebuild with WAIT_STATES=0 and with WAIT_STATES=3 → response after 1 and after 4 edges respectively; with BPW=4, write 0x01020304 at addr 8 → bytes [8..11]=01,02,03,04.
- Assert rst_n=0 mid-WAIT on a write of 0x5555 to addr 6 → outputs reset asynchronously, memory_array[6..7] unchanged, req_ready=1 after reset release.
